// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron activation stage.
// Optional build macro: LEAKY_RELU_EN (selects leaky ReLU in act_requant).
package nn_pkg;

  localparam int SUM_W       = 12;
  localparam int ACT_W       = 8;
  localparam int ACT_MAX     = 127;
  localparam int ACT_MIN     = -128;
  localparam int LEAKY_SHIFT = 3;

  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic signed [ACT_W-1:0] act_t;

endpackage

// File: rtl/act_requant.sv
// Combinational requantisation datapath: rounding right shift, ReLU
// (or leaky ReLU when LEAKY_RELU_EN is defined) and int8 saturation.
module act_requant
  import nn_pkg::*;
#(
  parameter int IN_W  = SUM_W,
  parameter int SHIFT = 2
) (
  input  logic signed [IN_W-1:0] sum_i,
  output act_t                   act_o,
  output logic                   sat_o
);

  // One extra bit so that adding the rounding constant cannot overflow.
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] RND   = (SHIFT > 0) ? RW'(1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : RW'(0);
  localparam logic signed [RW-1:0] MAX_R = RW'(ACT_MAX);

  logic signed [RW-1:0] ext_s;
  logic signed [RW-1:0] r_s;

  assign ext_s = $signed({sum_i[IN_W-1], sum_i}) + RND;
  assign r_s   = ext_s >>> SHIFT;

`ifdef LEAKY_RELU_EN
  localparam logic signed [RW-1:0] MIN_R = RW'(ACT_MIN);
  logic signed [RW-1:0] leak_s;
  assign leak_s = r_s >>> LEAKY_SHIFT;
`endif

  // Clamp the rounded value into the int8 activation range and flag clipping.
  always_comb begin
    act_o = act_t'(0);
    sat_o = 1'b0;
    if (r_s > MAX_R) begin
      act_o = act_t'(ACT_MAX);
      sat_o = 1'b1;
    end else if (r_s[RW-1]) begin
`ifdef LEAKY_RELU_EN
      if (leak_s < MIN_R) begin
        act_o = act_t'(ACT_MIN);
        sat_o = 1'b1;
      end else begin
        act_o = leak_s[ACT_W-1:0];
        sat_o = 1'b0;
      end
`else
      act_o = act_t'(0);
      sat_o = 1'b0;
`endif
    end else begin
      act_o = r_s[ACT_W-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/neuron_act_stage.sv
// Two-stage valid/ready activation pipeline with neuron index tracking,
// layer-done pulse and saturation event counter.
// Optional build macro: LEAKY_RELU_EN (leaky ReLU instead of plain ReLU).
module neuron_act_stage
  import nn_pkg::*;
#(
  parameter int IN_W        = SUM_W,
  parameter int OUT_W       = ACT_W,
  parameter int SHIFT       = 2,
  parameter int NUM_NEURONS = 8,
  parameter int CNT_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [IN_W-1:0]               in_sum,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [OUT_W-1:0]              out_act,
  output logic [$clog2(NUM_NEURONS)-1:0]       out_idx,
  output logic                                 layer_done,
  output logic [CNT_W-1:0]                     sat_count,
  input  logic                                 clr_stats
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  act_t             req_act_s;
  logic             req_sat_s;
  logic             s1_moves_s, in_ready_s, in_hs_s, out_hs_s;
  logic [IDX_W-1:0] idx_next_s;

  logic             s1_valid_q, s1_valid_d;
  act_t             s1_act_q, s1_act_d;
  logic             s1_sat_q, s1_sat_d;
  logic             out_valid_q, out_valid_d;
  act_t             out_act_q, out_act_d;
  logic             out_sat_q, out_sat_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             layer_done_q, layer_done_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  act_requant #(.IN_W(IN_W), .SHIFT(SHIFT)) u_requant (
    .sum_i (in_sum),
    .act_o (req_act_s),
    .sat_o (req_sat_s)
  );

  assign s1_moves_s = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready_s = !s1_valid_q || s1_moves_s;
  assign in_hs_s    = in_valid && in_ready_s;
  assign out_hs_s   = out_valid_q && out_ready;
  // idx_q is the index of the oldest not-yet-delivered output position.
  assign idx_next_s = (idx_q == IDX_LAST) ? IDX_W'(0) : idx_q + IDX_W'(1);

  // Next-state logic for both pipeline stages, index and statistics.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_act_d     = s1_act_q;
    s1_sat_d     = s1_sat_q;
    out_valid_d  = out_valid_q;
    out_act_d    = out_act_q;
    out_sat_d    = out_sat_q;
    out_idx_d    = out_idx_q;
    idx_d        = out_hs_s ? idx_next_s : idx_q;
    layer_done_d = out_hs_s && (idx_q == IDX_LAST);
    sat_count_d  = sat_count_q;

    if (in_hs_s) begin
      s1_valid_d = 1'b1;
      s1_act_d   = req_act_s;
      s1_sat_d   = req_sat_s;
    end else if (s1_moves_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // A sample entering S2 while the previous one leaves takes the next index.
    if (s1_moves_s) begin
      out_valid_d = 1'b1;
      out_act_d   = s1_act_q;
      out_sat_d   = s1_sat_q;
      out_idx_d   = out_hs_s ? idx_next_s : idx_q;
    end else if (out_hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (clr_stats) begin
      sat_count_d = CNT_W'(0);
    end else if (out_hs_s && out_sat_q && (sat_count_q != CNT_MAX)) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  // State registers; reset discards in-flight samples and rewinds the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_act_q     <= act_t'(0);
      s1_sat_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_act_q    <= act_t'(0);
      out_sat_q    <= 1'b0;
      out_idx_q    <= IDX_W'(0);
      idx_q        <= IDX_W'(0);
      layer_done_q <= 1'b0;
      sat_count_q  <= CNT_W'(0);
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_act_q     <= s1_act_d;
      s1_sat_q     <= s1_sat_d;
      out_valid_q  <= out_valid_d;
      out_act_q    <= out_act_d;
      out_sat_q    <= out_sat_d;
      out_idx_q    <= out_idx_d;
      idx_q        <= idx_d;
      layer_done_q <= layer_done_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_act    = out_act_q;
  assign out_idx    = out_idx_q;
  assign layer_done = layer_done_q;
  assign sat_count  = sat_count_q;

endmodule
